// File: rtl/tmds_channel_encoder.sv
// One TMDS channel: 8-bit pixel or 2-bit control code in, 10-bit DC-balanced symbol out.
// Stage 1 does transition minimisation; stage 2 does DC balance against the running disparity.
module tmds_channel_encoder #(
    parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              c0,
    input  logic              c1,
    input  logic              blank,
    output logic [9:0]        dout,
    output logic signed [4:0] disp
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = 10'b1101010100;
            2'b01:   code = 10'b0010101011;
            2'b10:   code = 10'b0101010100;
            default: code = 10'b1010101011;
        endcase
        return code;
    endfunction

    logic [8:0]        qm_p1_d, qm_p1_q;
    logic [3:0]        n1qm_p1_d, n1qm_p1_q;
    logic              blank_p1_q;
    logic [1:0]        ctl_p1_q;
    logic [9:0]        dout_p2_d, dout_p2_q;
    logic signed [4:0] disp_p2_d, disp_p2_q;

    // Stage 1: choose XOR/XNOR chaining to minimise transitions
    always_comb begin
        logic [3:0] n1d;
        logic       use_xnor;
        n1d       = popcount8(din);
        use_xnor  = (n1d > 4'd4) || ((n1d == 4'd4) && !din[0]);
        qm_p1_d   = '0;
        qm_p1_d[0] = din[0];
        for (int i = 1; i < 8; i++) begin
            qm_p1_d[i] = use_xnor ? ~(qm_p1_d[i-1] ^ din[i]) : (qm_p1_d[i-1] ^ din[i]);
        end
        qm_p1_d[8] = !use_xnor;
        n1qm_p1_d  = popcount8(qm_p1_d[7:0]);
    end

    // Stage 2: DC balance; bal is (ones - zeros) of q_m[7:0]
    always_comb begin
        logic signed [4:0] n1_s;
        logic signed [4:0] bal_s;
        logic signed [4:0] cnt_s;
        logic              q8;
        n1_s  = signed'({1'b0, n1qm_p1_q});
        bal_s = (n1_s <<< 1) - 5'sd8;
        cnt_s = disp_p2_q;
        q8    = qm_p1_q[8];
        dout_p2_d = ctrl_code(ctl_p1_q);
        disp_p2_d = '0;
        if (!blank_p1_q) begin
            if ((cnt_s == 5'sd0) || (n1qm_p1_q == 4'd4)) begin
                dout_p2_d = {~q8, q8, q8 ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
                disp_p2_d = q8 ? (cnt_s + bal_s) : (cnt_s - bal_s);
            end else if (((cnt_s > 5'sd0) && (n1qm_p1_q > 4'd4)) ||
                         ((cnt_s < 5'sd0) && (n1qm_p1_q < 4'd4))) begin
                dout_p2_d = {1'b1, q8, ~qm_p1_q[7:0]};
                disp_p2_d = cnt_s + (q8 ? 5'sd2 : 5'sd0) - bal_s;
            end else begin
                dout_p2_d = {1'b0, q8, qm_p1_q[7:0]};
                disp_p2_d = cnt_s - (q8 ? 5'sd0 : 5'sd2) + bal_s;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            qm_p1_q    <= '0;
            n1qm_p1_q  <= '0;
            blank_p1_q <= 1'b1;
            ctl_p1_q   <= 2'b00;
            dout_p2_q  <= RESET_SYMBOL;
            disp_p2_q  <= '0;
        end else begin
            qm_p1_q    <= qm_p1_d;
            n1qm_p1_q  <= n1qm_p1_d;
            blank_p1_q <= blank;
            ctl_p1_q   <= {c1, c0};
            dout_p2_q  <= dout_p2_d;
            disp_p2_q  <= disp_p2_d;
        end
    end

    assign dout = dout_p2_q;
    assign disp = disp_p2_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed vectors with hand-computed symbols,
// plus an independent TMDS decode of every active-video symbol.
module tb_tmds_channel_encoder;

    logic              pclk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        din = '0;
    logic              c0 = 1'b0;
    logic              c1 = 1'b0;
    logic              blank = 1'b1;
    logic [9:0]        dout;
    logic signed [4:0] disp;

    tmds_channel_encoder dut (
        .pclk  (pclk),
        .rst   (rst),
        .din   (din),
        .c0    (c0),
        .c1    (c1),
        .blank (blank),
        .dout  (dout),
        .disp  (disp)
    );

    always #20 pclk = ~pclk;

    typedef struct {
        int                id;
        int                due;
        logic [9:0]        dout;
        logic signed [4:0] disp;
        logic              act;
        logic [7:0]        din;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   vec = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    // Monitor: output is presented every cycle; compare whatever is due now.
    always @(negedge pclk) begin
        while (q.size() > 0 && q[0].due < cyc) begin
            n_checks++;
            n_fails++;
            $display("FAIL missed vec%0d: due cycle %0d, now %0d", q[0].id, q[0].due, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (dout !== e.dout) begin
                n_fails++;
                $display("FAIL dout vec%0d: got %h expected %h", e.id, dout, e.dout);
            end
            n_checks++;
            if (disp !== e.disp) begin
                n_fails++;
                $display("FAIL disp vec%0d: got %0d expected %0d", e.id, disp, e.disp);
            end
            if (e.act) begin
                n_checks++;
                if (tmds_decode(dout) !== e.din) begin
                    n_fails++;
                    $display("FAIL decode vec%0d: got %h expected %h", e.id, tmds_decode(dout), e.din);
                end
            end
        end
    end

    task automatic step(input logic r, input logic b, input logic [1:0] c, input logic [7:0] d,
                        input logic [9:0] xd, input int xs);
        exp_t e;
        rst   = r;
        blank = b;
        c1    = c[1];
        c0    = c[0];
        din   = d;
        e.id   = vec;
        e.due  = cyc + 2;
        e.dout = xd;
        e.disp = 5'(xs);
        e.act  = !b && !r && (xd != 10'h354);
        e.din  = d;
        q.push_back(e);
        vec++;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        // reset and control codes
        step(1, 1, 2'b00, 8'h00, 10'h354, 0);
        step(1, 1, 2'b00, 8'h00, 10'h354, 0);
        step(1, 1, 2'b00, 8'h00, 10'h354, 0);
        step(0, 1, 2'b00, 8'h00, 10'h354, 0);
        step(0, 1, 2'b01, 8'h00, 10'h0AB, 0);
        step(0, 1, 2'b10, 8'h00, 10'h154, 0);
        step(0, 1, 2'b11, 8'h00, 10'h2AB, 0);
        step(0, 1, 2'b00, 8'h00, 10'h354, 0);
        // active video, each branch of the balance logic
        step(0, 0, 2'b00, 8'h00, 10'h100, -8);
        step(0, 0, 2'b00, 8'h00, 10'h3FF, 2);
        step(0, 0, 2'b00, 8'h00, 10'h100, -6);
        step(0, 1, 2'b00, 8'h00, 10'h354, 0);
        step(0, 0, 2'b00, 8'hFF, 10'h200, -8);
        step(0, 0, 2'b00, 8'h00, 10'h3FF, 2);
        step(0, 0, 2'b00, 8'h55, 10'h133, 2);
        step(0, 0, 2'b00, 8'h10, 10'h1F0, 2);
        step(0, 0, 2'b00, 8'h01, 10'h300, -4);
        step(0, 0, 2'b00, 8'hFE, 10'h2FF, 4);
        step(0, 0, 2'b00, 8'h0F, 10'h105, 0);
        step(0, 0, 2'b00, 8'hF0, 10'h205, -4);
        step(0, 0, 2'b00, 8'h00, 10'h3FF, 6);
        // reset mid-line: this symbol is pre-empted by the reset on the next edge
        step(0, 0, 2'b00, 8'hFF, 10'h354, 0);
        step(1, 0, 2'b00, 8'hFF, 10'h354, 0);
        step(0, 0, 2'b00, 8'h00, 10'h100, -8);
        step(0, 0, 2'b00, 8'hFF, 10'h0FF, -2);
        step(0, 1, 2'b00, 8'h00, 10'h354, 0);
        rst = 1'b0; blank = 1'b1; c1 = 1'b0; c0 = 1'b0; din = '0;
        repeat (4) @(posedge pclk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
